// File: rtl/instr_encoder_loader.sv
// Program loader: encodes symbolic MIPS instruction fields into 32-bit words
// and writes them sequentially into the instruction memory write port.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op_sel,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [4:0]            shamt,
  input  logic [5:0]            funct,
  input  logic [15:0]           imm16,
  input  logic [25:0]           target26,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  full,
  output logic                  err,
  output logic                  err_sticky
);

  typedef enum logic [1:0] {StIdle, StWrite, StFull} state_t;

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CntOne   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);

  function automatic logic isLegal(input logic [3:0] opSel);
    return opSel <= 4'd10;
  endfunction

  function automatic logic [31:0] encodeWord(
    input logic [3:0]  opSel,
    input logic [4:0]  fRs,
    input logic [4:0]  fRt,
    input logic [4:0]  fRd,
    input logic [4:0]  fShamt,
    input logic [5:0]  fFunct,
    input logic [15:0] fImm,
    input logic [25:0] fTarget
  );
    logic [31:0] word;
    word = 32'd0;
    case (opSel)
      4'd0:    word = {6'h00, fRs, fRt, fRd, fShamt, fFunct};
      4'd1:    word = {6'h08, fRs, fRt, fImm};
      4'd2:    word = {6'h0d, fRs, fRt, fImm};
      4'd3:    word = {6'h0f, 5'd0, fRt, fImm};
      4'd4:    word = {6'h0c, fRs, fRt, fImm};
      4'd5:    word = {6'h23, fRs, fRt, fImm};
      4'd6:    word = {6'h2b, fRs, fRt, fImm};
      4'd7:    word = {6'h04, fRs, fRt, fImm};
      4'd8:    word = {6'h05, fRs, fRt, fImm};
      4'd9:    word = {6'h02, fTarget};
      4'd10:   word = {6'h03, fTarget};
      default: word = 32'd0;
    endcase
    return word;
  endfunction

  state_t              state;
  state_t              nextState;
  logic                accept;
  logic                legal;
  logic [ADDR_WIDTH:0] cntNext;

  assign in_ready = (state == StIdle);
  assign accept   = in_valid && in_ready;
  assign legal    = isLegal(op_sel);
  assign cntNext  = word_count + CntOne;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= StIdle;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    mem_we    = 1'b0;
    full      = 1'b0;
    case (state)
      StIdle:  if (accept && legal) nextState = StWrite;
      StWrite: begin
        mem_we    = 1'b1;
        nextState = (cntNext == DepthCnt) ? StFull : StIdle;
      end
      StFull:  full = 1'b1;
      default: nextState = StIdle;
    endcase
    // clear wins over any transfer; an in-flight write still completes this cycle
    if (clear) nextState = StIdle;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr   <= BaseAddr;
      word_count <= '0;
      mem_wdata  <= 32'd0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else if (clear) begin
      mem_addr   <= BaseAddr;
      word_count <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (accept && !legal) err_sticky <= 1'b1;
      if (accept && legal)
        mem_wdata <= encodeWord(op_sel, rs, rt, rd, shamt, funct, imm16, target26);
      if (state == StWrite) begin
        mem_addr   <= mem_addr + AddrOne;
        word_count <= cntNext;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: table of encodings plus hand sequences
// for handshake, illegal op, full, clear and asynchronous reset corner cases.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid;
  logic        in_ready, mem_we, full, err, err_sticky;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  word_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  instr_encoder_loader #(.ADDR_WIDTH(6), .DEPTH(4), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .target26(target26), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .word_count(word_count), .full(full), .err(err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setFields(input vec_t v);
    op_sel = v.op; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.sh;
    funct = v.fn; imm16 = v.imm; target26 = v.tgt;
  endtask

  task automatic scramble();
    op_sel = 4'(($urandom % 11)); rs = 5'($urandom); rt = 5'($urandom);
    rd = 5'($urandom); shamt = 5'($urandom); funct = 6'($urandom);
    imm16 = 16'($urandom); target26 = 26'($urandom);
  endtask

  // One transfer followed by the write cycle and the post-write counters.
  task automatic sendVec(input vec_t v, input logic [5:0] addr, input string tag);
    @(negedge clk);
    chk({tag, " ready"}, 32'(in_ready), 32'd1);
    setFields(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    chk({tag, " we"}, 32'(mem_we), 32'd1);
    chk({tag, " addr"}, 32'(mem_addr), 32'(addr));
    chk({tag, " wdata"}, mem_wdata, v.exp);
    chk({tag, " busy"}, 32'(in_ready), 32'd0);
    chk({tag, " noerr"}, 32'(err), 32'd0);
    @(posedge clk); #1;
    chk({tag, " we_off"}, 32'(mem_we), 32'd0);
    chk({tag, " addr_inc"}, 32'(mem_addr), 32'(addr) + 32'd1);
    chk({tag, " count"}, 32'(word_count), 32'(addr) + 32'd1);
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic checkIdleReset(input string tag);
    chk({tag, " we"}, 32'(mem_we), 32'd0);
    chk({tag, " addr"}, 32'(mem_addr), 32'd0);
    chk({tag, " count"}, 32'(word_count), 32'd0);
    chk({tag, " full"}, 32'(full), 32'd0);
    chk({tag, " ready"}, 32'(in_ready), 32'd1);
    chk({tag, " err"}, 32'(err), 32'd0);
    chk({tag, " sticky"}, 32'(err_sticky), 32'd0);
  endtask

  initial begin
    //        op     rs     rt     rd     sh     fn      imm        tgt            exp
    vecs[0]  = '{4'd1,  5'd2,  5'd3,  5'd9,  5'd1,  6'h3f, 16'h0005, 26'h3ffffff, 32'h20430005};
    vecs[1]  = '{4'd0,  5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'hffff, 26'h155aa55, 32'h00221820};
    vecs[2]  = '{4'd3,  5'd7,  5'd4,  5'd1,  5'd2,  6'h01, 16'h1001, 26'h0000001, 32'h3C041001};
    vecs[3]  = '{4'd9,  5'd31, 5'd31, 5'd31, 5'd31, 6'h3f, 16'hffff, 26'h0100004, 32'h08100004};
    vecs[4]  = '{4'd10, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0100004, 32'h0C100004};
    vecs[5]  = '{4'd2,  5'd5,  5'd6,  5'd7,  5'd3,  6'h11, 16'hBEEF, 26'h2222222, 32'h34A6BEEF};
    vecs[6]  = '{4'd4,  5'd1,  5'd1,  5'd0,  5'd0,  6'h00, 16'h00FF, 26'h0000000, 32'h302100FF};
    vecs[7]  = '{4'd5,  5'd29, 5'd8,  5'd0,  5'd0,  6'h00, 16'h0010, 26'h0000000, 32'h8FA80010};
    vecs[8]  = '{4'd6,  5'd29, 5'd9,  5'd0,  5'd0,  6'h00, 16'h0014, 26'h0000000, 32'hAFA90014};
    vecs[9]  = '{4'd7,  5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'hFFFE, 26'h0000000, 32'h1022FFFE};
    vecs[10] = '{4'd8,  5'd3,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0003, 26'h0000000, 32'h14600003};
    vecs[11] = '{4'd0,  5'd0,  5'd5,  5'd6,  5'd4,  6'h00, 16'h0000, 26'h0000000, 32'h00053100};

    reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
    setFields(vecs[0]);
    #1;
    checkIdleReset("reset");
    chk("reset wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Table: four words per fill, then full, then clear back to empty.
    for (int i = 0; i < 12; i++) begin
      sendVec(vecs[i], 6'(i % 4), $sformatf("vec%0d", i));
      if (i % 4 == 3) begin
        chk($sformatf("full%0d flag", i), 32'(full), 32'd1);
        chk($sformatf("full%0d ready", i), 32'(in_ready), 32'd0);
        if (i == 3) begin
          @(negedge clk);
          setFields(vecs[4]);
          in_valid = 1'b1;
          for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("fifth we c%0d", c), 32'(mem_we), 32'd0);
            chk($sformatf("fifth count c%0d", c), 32'(word_count), 32'd4);
          end
          in_valid = 1'b0;
        end
        pulseClear();
        checkIdleReset($sformatf("clr%0d", i));
      end
    end

    // Back-to-back R then LUI with in_valid held high.
    @(negedge clk);
    setFields(vecs[1]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b r we", 32'(mem_we), 32'd1);
    chk("b2b r ready", 32'(in_ready), 32'd0);
    chk("b2b r wdata", mem_wdata, 32'h00221820);
    setFields(vecs[2]);
    @(posedge clk); #1;
    chk("b2b gap we", 32'(mem_we), 32'd0);
    chk("b2b gap ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b lui we", 32'(mem_we), 32'd1);
    chk("b2b lui addr", 32'(mem_addr), 32'd1);
    chk("b2b lui wdata", mem_wdata, 32'h3C041001);
    chk("b2b lui ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("b2b count", 32'(word_count), 32'd2);
    pulseClear();

    // Illegal op_sel: err pulse, sticky flag, no write, address kept.
    @(negedge clk);
    setFields(vecs[0]);
    op_sel = 4'd12;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ill err", 32'(err), 32'd1);
    chk("ill sticky", 32'(err_sticky), 32'd1);
    chk("ill we", 32'(mem_we), 32'd0);
    chk("ill count", 32'(word_count), 32'd0);
    chk("ill ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("ill err pulse", 32'(err), 32'd0);
    chk("ill sticky hold", 32'(err_sticky), 32'd1);
    chk("ill we2", 32'(mem_we), 32'd0);
    sendVec(vecs[0], 6'd0, "after_ill");
    chk("ill sticky kept", 32'(err_sticky), 32'd1);
    pulseClear();
    chk("clr sticky", 32'(err_sticky), 32'd0);

    // Clear during WRITE: write completes, counters not incremented.
    @(negedge clk);
    setFields(vecs[5]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    chk("clrw we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    clear = 1'b0;
    checkIdleReset("clrw");

    // Clear coincident with a transfer in IDLE drops the transfer.
    @(negedge clk);
    setFields(vecs[1]);
    clear = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    checkIdleReset("clrx");
    @(posedge clk); #1;
    chk("clrx we2", 32'(mem_we), 32'd0);

    // Asynchronous reset during WRITE.
    @(negedge clk);
    setFields(vecs[6]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rstw we before", 32'(mem_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkIdleReset("rstw");
    chk("rstw wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sendVec(vecs[7], 6'd0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the opcode control decoder: accepts symbolic instruction fields over a valid/ready handshake and encodes them into 32-bit MIPS words.
- Encodes the same opcode set the control decoder recognises.
- Writes the encoded words sequentially into the instruction memory write port.
- Used by the bench/boot path to load programs into instruction memory before the core runs.

Parameters:
ADDR_WIDTH, 6, word-address width of instruction memory write port
DEPTH, 64, maximum words loaded before FULL (must be <= 2**ADDR_WIDTH)
BASE_ADDR, 0, word address of first write after reset/clear

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous restart: address/count/flags back to reset values
in_valid  input  1  instruction fields valid
in_ready  output  1  encoder can accept fields this cycle
op_sel  input  4  0=R,1=ADDI,2=ORI,3=LUI,4=ANDI,5=LW,6=SW,7=BEQ,8=BNE,9=J,10=JAL; 11-15 illegal
rs  input  5  source register
rt  input  5  target register
rd  input  5  destination register (R only)
shamt  input  5  shift amount (R only)
funct  input  6  function code (R only)
imm16  input  16  immediate / branch offset (I-types)
target26  input  26  jump target (J, JAL)
mem_we  output  1  instruction memory write enable
mem_addr  output  ADDR_WIDTH  write word address
mem_wdata  output  32  encoded instruction
word_count  output  ADDR_WIDTH+1  words written since reset/clear
full  output  1  word_count == DEPTH
err  output  1  one-cycle pulse on illegal op_sel accepted
err_sticky  output  1  set by err, cleared only by reset/clear

Behaviour:
- Reset (reset==0, async) values:
  - state=IDLE; in_ready=1; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0.
  - word_count=0; full=0; err=0; err_sticky=0.
- Handshake:
  - Transfer occurs on a rising edge with in_valid&in_ready.
  - Fields are registered at the transfer edge; inputs are don't-care afterwards.
- States:
  - IDLE:
    - in_ready=1 while not full.
    - A legal transfer goes to WRITE.
    - An illegal op_sel transfer stays in IDLE, err=1 for the next cycle, err_sticky set, no write, address unchanged.
  - WRITE:
    - in_ready=0; mem_we=1 for exactly one cycle, with mem_addr/mem_wdata stable.
    - On exit: mem_addr+1, word_count+1, then IDLE, or FULL if word_count reaches DEPTH.
  - FULL:
    - in_ready=0; full=1; mem_we=0.
    - Leaves only on clear or reset.
- Latency and throughput:
  - Transfer at edge N gives mem_we high during cycle N..N+1.
  - Maximum throughput is one word per 2 cycles.
- Encoding (mem_wdata registered at transfer):
  - R: {6'h00,rs,rt,rd,shamt,funct}.
  - ADDI 6'h08, ORI 6'h0d, ANDI 6'h0c, LW 6'h23, SW 6'h2b, BEQ 6'h04, BNE 6'h05: {op,rs,rt,imm16}.
  - LUI 6'h0f: {op,5'd0,rt,imm16}; rs is ignored.
  - J 6'h02, JAL 6'h03: {op,target26}.
- mem_addr wraps modulo 2**ADDR_WIDTH. This is unreachable when DEPTH <= 2**ADDR_WIDTH and matters only for BASE_ADDR offsets.
- clear:
  - Synchronous; priority over a transfer in the same cycle (the transfer is dropped).
  - Sends state to IDLE and restores reset values of mem_addr, word_count, full, err, err_sticky.
  - clear during WRITE: mem_we stays asserted for that cycle only (the write completes); counters go to reset values, not incremented.
- Reset mid-operation: an asynchronous drop of mem_we is allowed; no partial state survives.
- err and mem_we are never high in the same cycle.

Test Plan:
- Reset, then transfer op_sel=1 (ADDI) with rs=2, rt=3, imm16=16'h0005 -> next cycle mem_we=1, mem_addr=0, mem_wdata=32'h20430005; then word_count=1, mem_addr=1.
- Back-to-back R (rs=1, rt=2, rd=3, shamt=0, funct=6'h20) and LUI (rs=7, rt=4, imm16=16'h1001):
  - in_ready low on alternate cycles.
  - Words 32'h00221820 at addr 0 and 32'h3C041001 at addr 1 (rs ignored).
- J target26=26'h0100004 then JAL same target -> 32'h08100004 and 32'h0C100004 at consecutive addresses.
- op_sel=12 transferred -> err pulses one cycle, err_sticky=1, mem_we stays 0, word_count unchanged; next legal word written at the unchanged address.
- DEPTH=4: five valid words offered -> four writes (addr 0..3), full=1, in_ready=0 after the 4th; clear -> full=0, word_count=0, mem_addr=0, in_ready=1.
- Assert reset low during WRITE -> mem_we drops immediately, all outputs at reset values; clear coincident with in_valid in IDLE -> no write, no err.
